// File: rtl/pe_stream_fifo.sv
// Synchronous stream FIFO for the PE input path: registered read data, occupancy
// status and sticky overflow/underflow flags. Define PE_FIFO_ALMOST_EN to build almost_full.
module pe_stream_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    input  logic                  err_clear,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                  DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] CNT_ZERO = (ADDR_WIDTH + 1)'(0);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = ADDR_WIDTH'(0);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [ADDR_WIDTH:0]   count_r;
    logic [DATA_WIDTH-1:0] dout_r;
    logic                  dout_valid_r;
    logic                  overflow_r;
    logic                  underflow_r;
    logic                  full_s;
    logic                  empty_s;
    logic                  push_ok_s;
    logic                  pop_ok_s;

    assign full_s  = (count_r == DEPTH_C);
    assign empty_s = (count_r == CNT_ZERO);

    // A push at full is still accepted when a pop frees the oldest slot in the same cycle.
    assign push_ok_s = push & (~full_s | pop);
    assign pop_ok_s  = pop & ~empty_s;

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Registered read port; dout holds unless a pop is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_r       <= {DATA_WIDTH{1'b0}};
            dout_valid_r <= 1'b0;
        end else begin
            dout_valid_r <= pop_ok_s;
            if (pop_ok_s) begin
                dout_r <= mem_r[rd_ptr_r];
            end
        end
    end

    // Sticky error flags: a new error in the clearing cycle wins over err_clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= (push & ~push_ok_s) | (overflow_r & ~err_clear);
            underflow_r <= (pop & empty_s) | (underflow_r & ~err_clear);
        end
    end

`ifdef PE_FIFO_ALMOST_EN
    localparam logic [ADDR_WIDTH:0] AF_C = (ADDR_WIDTH + 1)'(AF_LEVEL);
    assign almost_full = (count_r >= AF_C);
`else
    assign almost_full = 1'b0;
    // Threshold is irrelevant in this build; the empty block only keeps it referenced.
    if (AF_LEVEL > DEPTH) begin : g_af_level_unreachable
    end
`endif

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign full       = full_s;
    assign empty      = empty_s;
    assign count      = count_r;
    assign overflow   = overflow_r;
    assign underflow  = underflow_r;

endmodule

// File: tb/tb_pe_stream_fifo.sv
// Self-checking bench for pe_stream_fifo: queue-based reference model compared on
// every negedge, directed boundary scenarios with literal expectations, then random traffic.
module tb_pe_stream_fifo;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam int AF = 12;

    logic          clk;
    logic          reset;
    logic          push;
    logic [DW-1:0] din;
    logic          pop;
    logic          err_clear;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          almost_full;
    logic          overflow;
    logic          underflow;

    pe_stream_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF)) dut (
        .clk(clk), .reset(reset), .push(push), .din(din), .pop(pop),
        .err_clear(err_clear), .dout(dout), .dout_valid(dout_valid),
        .full(full), .empty(empty), .count(count), .almost_full(almost_full),
        .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    // Reference model state
    logic [DW-1:0] q_m[$];
    logic [DW-1:0] exp_dout;
    logic          exp_valid;
    logic          exp_ovf;
    logic          exp_unf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_af();
`ifdef PE_FIFO_ALMOST_EN
        return (q_m.size() >= AF);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        q_m.delete();
        exp_dout  = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
    endtask

    task automatic model_step(input logic p, input logic [DW-1:0] d, input logic q, input logic c);
        bit was_full;
        bit was_empty;
        bit p_ok;
        bit q_ok;
        was_full  = (q_m.size() == DEPTH);
        was_empty = (q_m.size() == 0);
        q_ok = q && !was_empty;
        p_ok = p && (!was_full || q);
        exp_valid = q_ok;
        if (q_ok) exp_dout = q_m.pop_front();
        if (p_ok) q_m.push_back(d);
        exp_ovf = (p && !p_ok) || (exp_ovf && !c);
        exp_unf = (q && was_empty) || (exp_unf && !c);
    endtask

    task automatic cyc(input logic p, input logic [DW-1:0] d, input logic q, input logic c);
        push = p; din = d; pop = q; err_clear = c;
        @(posedge clk);
        model_step(p, d, q, c);
        @(negedge clk);
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("count", 32'(count), 32'(q_m.size()));
            chk("full", 32'(full), 32'(q_m.size() == DEPTH));
            chk("empty", 32'(empty), 32'(q_m.size() == 0));
            chk("almost_full", 32'(almost_full), 32'(exp_af()));
            chk("dout_valid", 32'(dout_valid), 32'(exp_valid));
            chk("dout", 32'(dout), 32'(exp_dout));
            chk("overflow", 32'(overflow), 32'(exp_ovf));
            chk("underflow", 32'(underflow), 32'(exp_unf));
        end
    end

    initial begin
        push = 1'b0; din = '0; pop = 1'b0; err_clear = 1'b0;
        reset = 1'b1;
        model_reset();
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_af", 32'(almost_full), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check_en = 1'b1;

        // Fill/drain twice to wrap pointers
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 1; i <= 16; i++) begin
                cyc(1'b1, 16'(i), 1'b0, 1'b0);
`ifdef PE_FIFO_ALMOST_EN
                chk("af_fill", 32'(almost_full), 32'(i >= 12));
`else
                chk("af_off", 32'(almost_full), 32'd0);
`endif
            end
            chk("fill_full", 32'(full), 32'd1);
            chk("fill_count", 32'(count), 32'd16);
            for (int i = 1; i <= 16; i++) begin
                cyc(1'b0, 16'h0000, 1'b1, 1'b0);
                chk("drain_dout", 32'(dout), 32'(i));
                chk("drain_valid", 32'(dout_valid), 32'd1);
`ifdef PE_FIFO_ALMOST_EN
                chk("af_drain", 32'(almost_full), 32'(16 - i >= 12));
`endif
            end
            chk("drain_empty", 32'(empty), 32'd1);
        end

        // Overflow at full, then clear
        for (int i = 0; i < 16; i++) cyc(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0);
        cyc(1'b1, 16'hBEEF, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 16'h0000, 1'b1, 1'b0);
            chk("ovf_no_beef", 32'(dout == 16'hBEEF), 32'd0);
        end
        cyc(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("ovf_clear", 32'(overflow), 32'd0);

        // Full with push and pop together
        for (int i = 1; i <= 16; i++) cyc(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0);
        cyc(1'b1, 16'h3333, 1'b1, 1'b0);
        chk("fullpp_count", 32'(count), 32'd16);
        chk("fullpp_dout", 32'(dout), 32'h2001);
        chk("fullpp_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("fullpp_last", 32'(dout), 32'h3333);

        // Empty with push and pop together
        cyc(1'b1, 16'h00AA, 1'b1, 1'b0);
        chk("emptypp_unf", 32'(underflow), 32'd1);
        chk("emptypp_count", 32'(count), 32'd1);
        chk("emptypp_valid", 32'(dout_valid), 32'd0);
        cyc(1'b0, 16'h0000, 1'b1, 1'b1);
        chk("emptypp_dout", 32'(dout), 32'h00AA);
        chk("unf_clear", 32'(underflow), 32'd0);

        // Flag-generator bursts of 8 (W=3)
        for (int i = 0; i < 8; i++) cyc(1'b1, 16'h4000 + 16'(i), 1'b0, 1'b0);
        chk("burst0_count", 32'(count), 32'd8);
        chk("burst0_ovf", 32'(overflow), 32'd0);
        cyc(1'b1, 16'h4100, 1'b0, 1'b0);
        cyc(1'b1, 16'h4101, 1'b0, 1'b0);
        chk("pre_burst_count", 32'(count), 32'd10);
        for (int i = 0; i < 8; i++) cyc(1'b1, 16'h4200 + 16'(i), 1'b0, 1'b0);
        chk("burst1_count", 32'(count), 32'd16);
        chk("burst1_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("burst1_last", 32'(dout), 32'h4205);
        cyc(1'b0, 16'h0000, 1'b0, 1'b1);

        // Asynchronous reset mid-cycle with count=5
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'h5000 + 16'(i), 1'b0, 1'b0);
        cyc(1'b1, 16'h5005, 1'b1, 1'b0);
        cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("pre_reset_count", 32'(count), 32'd4);
        cyc(1'b1, 16'h5006, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_dout", 32'(dout), 32'd0);
        chk("arst_valid", 32'(dout_valid), 32'd0);
        chk("arst_flags", 32'({overflow, underflow}), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic with shifting push/pop bias
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = (i / 300) % 3;
            cyc(($urandom_range(0, 9) < 3 + 2 * bias) ? 1'b1 : 1'b0,
                16'($urandom()),
                ($urandom_range(0, 9) < 7 - 2 * bias) ? 1'b1 : 1'b0,
                ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
        end

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
